tx_fm0_encoder: RTL and testbench
=================================

TX_FM0_ENCODER -- requirements
Module: tx_fm0_encoder

Interface
REQ-001 SHALL have parameter MAX_BITS, default 512, meaning the maximum number of data bits per reply before a forced end.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; one period is one FM0 half-symbol (2xBLF).
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port tx_start, input, 1 bit: single-cycle request to begin a reply.
REQ-005 SHALL have port trext, input, 1 bit: sampled with tx_start; 1 selects the pilot-tone prefix.
REQ-006 SHALL have port tx_bit_src, input, 1 bit: the current data bit from the memory interface.
REQ-007 SHALL have port tx_data_done, input, 1 bit: marks the bit sampled on the same edge as the last data bit.
REQ-008 SHALL have port bit_req, output, 1 bit: high for one cycle while a data bit is being consumed.
REQ-009 SHALL have port tx_out, output, 1 bit: the backscatter modulator drive.
REQ-010 SHALL have port tx_active, output, 1 bit: high from the first to the last half-symbol.
REQ-011 SHALL have port tx_done, output, 1 bit: single-cycle pulse after the final half-symbol.
REQ-012 SHALL have port tx_overrun, output, 1 bit: sticky flag set when MAX_BITS is reached without tx_data_done.

Function
REQ-013 SHALL implement states IDLE, PILOT, PREAMBLE, DATA, CRC, DUMMY and DONE; every state except IDLE and DONE SHALL drive tx_active=1.
REQ-014 SHALL move from IDLE to PILOT on tx_start when trext=1, and to PREAMBLE when trext=0; the first half-symbol SHALL appear on tx_out in the cycle after tx_start.
REQ-015 SHALL ignore tx_start outside IDLE.
REQ-016 SHALL, in PILOT, output 24 half-symbols alternating 1,0,1,0,... starting with 1, then enter PREAMBLE.
REQ-017 SHALL, in PREAMBLE, output the fixed 12 half-symbols 110100100011 left to right, then set the line level register lvl=1 and enter DATA.
REQ-018 SHALL encode each FM0 symbol as follows: first half is lvl inverted (lvl updated); second half is unchanged for bit 1 and inverted again (lvl updated) for bit 0.
REQ-019 SHALL assert bit_req during the first half of each DATA symbol and sample tx_bit_src and tx_data_done on the clk edge that ends that cycle; the sampled bit SHALL drive the second half with zero added latency.
REQ-020 SHALL count data bits with a counter wide enough for MAX_BITS; after the bit flagged by tx_data_done, or after bit MAX_BITS, it SHALL leave DATA.
REQ-021 SHALL set tx_overrun when it leaves DATA on the MAX_BITS limit without tx_data_done; tx_overrun SHALL clear only on reset or the next accepted tx_start.
REQ-022 SHALL run CRC-16 over data bits: polynomial 0x1021, preset 0xFFFF on tx_start, updated once per sampled bit.
REQ-023 SHALL, in CRC, transmit the ones-complement of the CRC register MSB first, as 16 FM0 symbols, with bit_req low.
REQ-024 SHALL, in DUMMY, transmit one FM0 data-1 symbol, then enter DONE.
REQ-025 SHALL, in DONE, drive tx_out=0 and tx_active=0, pulse tx_done for one cycle, and return to IDLE.
REQ-026 SHALL keep tx_out=0, bit_req=0 and tx_done=0 in IDLE.
REQ-027 SHALL treat tx_data_done on the first data bit as a valid 1-bit reply.

Reset
REQ-028 SHALL, on reset assertion, immediately force state=IDLE, tx_out=0, tx_active=0, bit_req=0, tx_done=0, tx_overrun=0, lvl=0, all counters 0 and CRC=0xFFFF, including in the middle of a reply.
REQ-029 SHALL not emit tx_done for a reply aborted by reset.

Configuration
REQ-030 SHALL, with macro TX_CRC16_EN defined, include the CRC register and the CRC state, with DATA going to CRC.
REQ-031 SHALL, without TX_CRC16_EN, omit the CRC logic and go from DATA directly to DUMMY; all other timing SHALL be unchanged.

Verification
REQ-032 SHALL cover: TX_CRC16_EN off, trext=0, one bit 1 with tx_data_done -> tx_out=1101001000110011 over 16 cycles, tx_done in cycle 17.
REQ-033 SHALL cover: TX_CRC16_EN off, bits 1,0 -> data half-symbols 00 then 10, dummy 11.
REQ-034 SHALL cover: TX_CRC16_EN on, 16 data bits 0x0000 -> CRC field carries 0xE2F0 MSB first, 1+12+32+32+2 cycles through tx_done.
REQ-035 SHALL cover: trext=1 -> 24 alternating half-symbols 1010... precede the preamble; tx_start during the reply is ignored.
REQ-036 SHALL cover: tx_data_done never asserted -> exactly MAX_BITS bit_req pulses, then tx_overrun=1, CRC and dummy still sent.
REQ-037 SHALL cover: reset asserted at data bit 5 -> tx_out=0 and tx_active=0 asynchronously, no tx_done, and the next tx_start runs a full reply.

Source files
------------

// File: rtl/tx_fm0_if.sv
// Request/data/status bundle between the reply controller and the FM0 encoder.
interface tx_fm0_if;
    logic tx_start;
    logic trext;
    logic tx_bit_src;
    logic tx_data_done;
    logic bit_req;
    logic tx_out;
    logic tx_active;
    logic tx_done;
    logic tx_overrun;

    modport master (
        output tx_start, trext, tx_bit_src, tx_data_done,
        input  bit_req, tx_out, tx_active, tx_done, tx_overrun
    );

    modport slave (
        input  tx_start, trext, tx_bit_src, tx_data_done,
        output bit_req, tx_out, tx_active, tx_done, tx_overrun
    );
endinterface

// File: rtl/tx_fm0_encoder.sv
// FM0 reply encoder: optional pilot tone, preamble, data, CRC-16 and dummy-1 trailer.
// The CRC-16 field is built only when the macro TX_CRC16_EN is defined.
module tx_fm0_encoder #(
    parameter int unsigned MAX_BITS = 512
) (
    input  logic    clk,
    input  logic    reset,
    tx_fm0_if.slave bus
);
    localparam int unsigned BIT_CNT_W = $clog2(MAX_BITS + 1);
    localparam int unsigned HS_CNT_W  = 5;
    localparam int unsigned PILOT_LEN = 24;
    localparam int unsigned PRE_LEN   = 12;
    localparam int unsigned CRC_W     = 16;
    // Preamble left-aligned in 16 bits so the lookahead index never leaves the vector
    localparam logic [15:0] PRE_PAT   = {12'b110100100011, 4'b0000};
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_PRESET = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_PILOT, S_PREAMBLE, S_DATA, S_CRC, S_DUMMY, S_DONE
    } state_t;

    state_t                r_state,      w_state_nx;
    logic [HS_CNT_W-1:0]   r_hs_cnt,     w_hs_cnt_nx;
    logic [BIT_CNT_W-1:0]  r_bit_cnt,    w_bit_cnt_nx;
    logic                  r_half,       w_half_nx;
    logic                  r_lvl,        w_lvl_nx;
    logic                  r_last,       w_last_nx;
    logic                  r_limit,      w_limit_nx;
    logic                  r_tx_out,     w_tx_out_nx;
    logic                  r_bit_req,    w_bit_req_nx;
    logic                  r_tx_active,  w_tx_active_nx;
    logic                  r_tx_done,    w_tx_done_nx;
    logic                  r_tx_overrun, w_tx_overrun_nx;
    logic [3:0]            w_pre_nx_idx;
    logic                  w_at_limit;
`ifdef TX_CRC16_EN
    logic [CRC_W-1:0]      r_crc,        w_crc_nx;
    logic                  w_crc_fb;
    logic                  w_crc_bit;

    assign w_crc_fb  = r_crc[CRC_W-1] ^ bus.tx_bit_src;
    assign w_crc_bit = ~r_crc[4'(CRC_W - 1) - 4'(r_hs_cnt)];
`endif

    assign w_pre_nx_idx = 4'(14) - 4'(r_hs_cnt);
    assign w_at_limit   = (r_bit_cnt == BIT_CNT_W'(MAX_BITS - 1));

    // Next-state and next-output logic; every output is registered
    always_comb begin
        w_state_nx      = r_state;
        w_hs_cnt_nx     = r_hs_cnt;
        w_bit_cnt_nx    = r_bit_cnt;
        w_half_nx       = r_half;
        w_lvl_nx        = r_lvl;
        w_last_nx       = r_last;
        w_limit_nx      = r_limit;
        w_tx_out_nx     = r_tx_out;
        w_bit_req_nx    = 1'b0;
        w_tx_done_nx    = 1'b0;
        w_tx_overrun_nx = r_tx_overrun;
`ifdef TX_CRC16_EN
        w_crc_nx        = r_crc;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.tx_start) begin
                    w_state_nx      = bus.trext ? S_PILOT : S_PREAMBLE;
                    w_tx_out_nx     = 1'b1;
                    w_hs_cnt_nx     = '0;
                    w_bit_cnt_nx    = '0;
                    w_half_nx       = 1'b0;
                    w_tx_overrun_nx = 1'b0;
`ifdef TX_CRC16_EN
                    w_crc_nx        = CRC_PRESET;
`endif
                end
            end
            S_PILOT: begin
                if (r_hs_cnt == HS_CNT_W'(PILOT_LEN - 1)) begin
                    w_state_nx  = S_PREAMBLE;
                    w_hs_cnt_nx = '0;
                    w_tx_out_nx = PRE_PAT[15];
                end else begin
                    w_hs_cnt_nx = r_hs_cnt + 1'b1;
                    w_tx_out_nx = ~r_tx_out;
                end
            end
            S_PREAMBLE: begin
                if (r_hs_cnt == HS_CNT_W'(PRE_LEN - 1)) begin
                    // Line level is 1 after the preamble; first data half is its inverse
                    w_state_nx   = S_DATA;
                    w_tx_out_nx  = 1'b0;
                    w_lvl_nx     = 1'b0;
                    w_half_nx    = 1'b0;
                    w_bit_req_nx = 1'b1;
                end else begin
                    w_hs_cnt_nx = r_hs_cnt + 1'b1;
                    w_tx_out_nx = PRE_PAT[w_pre_nx_idx];
                end
            end
            S_DATA: begin
                if (!r_half) begin
                    w_half_nx    = 1'b1;
                    w_tx_out_nx  = bus.tx_bit_src ? r_lvl : ~r_lvl;
                    w_lvl_nx     = w_tx_out_nx;
                    w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    w_last_nx    = bus.tx_data_done || w_at_limit;
                    w_limit_nx   = !bus.tx_data_done && w_at_limit;
`ifdef TX_CRC16_EN
                    w_crc_nx     = {r_crc[CRC_W-2:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : '0);
`endif
                end else begin
                    w_half_nx   = 1'b0;
                    w_tx_out_nx = ~r_lvl;
                    w_lvl_nx    = ~r_lvl;
                    if (r_last) begin
                        w_tx_overrun_nx = r_tx_overrun | r_limit;
                        w_hs_cnt_nx     = '0;
`ifdef TX_CRC16_EN
                        w_state_nx      = S_CRC;
`else
                        w_state_nx      = S_DUMMY;
`endif
                    end else begin
                        w_bit_req_nx = 1'b1;
                    end
                end
            end
`ifdef TX_CRC16_EN
            S_CRC: begin
                if (!r_half) begin
                    w_half_nx   = 1'b1;
                    w_tx_out_nx = w_crc_bit ? r_lvl : ~r_lvl;
                    w_lvl_nx    = w_tx_out_nx;
                end else begin
                    w_half_nx   = 1'b0;
                    w_tx_out_nx = ~r_lvl;
                    w_lvl_nx    = ~r_lvl;
                    if (r_hs_cnt == HS_CNT_W'(CRC_W - 1)) begin
                        w_state_nx = S_DUMMY;
                    end else begin
                        w_hs_cnt_nx = r_hs_cnt + 1'b1;
                    end
                end
            end
`endif
            S_DUMMY: begin
                if (!r_half) begin
                    w_half_nx = 1'b1;
                end else begin
                    w_half_nx    = 1'b0;
                    w_state_nx   = S_DONE;
                    w_tx_out_nx  = 1'b0;
                    w_tx_done_nx = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx  = S_IDLE;
                w_tx_out_nx = 1'b0;
                w_half_nx   = 1'b0;
            end
        endcase
        w_tx_active_nx = (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_hs_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_half       <= 1'b0;
            r_lvl        <= 1'b0;
            r_last       <= 1'b0;
            r_limit      <= 1'b0;
            r_tx_out     <= 1'b0;
            r_bit_req    <= 1'b0;
            r_tx_active  <= 1'b0;
            r_tx_done    <= 1'b0;
            r_tx_overrun <= 1'b0;
`ifdef TX_CRC16_EN
            r_crc        <= CRC_PRESET;
`endif
        end else begin
            r_state      <= w_state_nx;
            r_hs_cnt     <= w_hs_cnt_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_half       <= w_half_nx;
            r_lvl        <= w_lvl_nx;
            r_last       <= w_last_nx;
            r_limit      <= w_limit_nx;
            r_tx_out     <= w_tx_out_nx;
            r_bit_req    <= w_bit_req_nx;
            r_tx_active  <= w_tx_active_nx;
            r_tx_done    <= w_tx_done_nx;
            r_tx_overrun <= w_tx_overrun_nx;
`ifdef TX_CRC16_EN
            r_crc        <= w_crc_nx;
`endif
        end
    end

    assign bus.tx_out     = r_tx_out;
    assign bus.bit_req    = r_bit_req;
    assign bus.tx_active  = r_tx_active;
    assign bus.tx_done    = r_tx_done;
    assign bus.tx_overrun = r_tx_overrun;
endmodule

// File: tb/tb_tx_fm0_encoder.sv
// Scoreboard bench for tx_fm0_encoder: a reference model queues expected {bit_req, tx_out}
// half-symbols per reply and a monitor compares them; CRC field follows TX_CRC16_EN.
module tb_tx_fm0_encoder;
    localparam int MAXB   = 40;
    localparam int BUDGET = 400;
    localparam logic [11:0] PRE = 12'b110100100011;

    typedef struct {
        int nreq;
        bit ovr;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tx_fm0_if bif();

    tx_fm0_encoder #(.MAX_BITS(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];
    rec_t       rec_q[$];
    bit         data_q[$];
    bit         stim_bits[$];
    bit         give_done = 1'b0;
    bit         m_lvl = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One FM0 symbol: invert at the start, invert again mid-symbol for a 0
    task automatic push_sym(input bit b, input bit req);
        m_lvl = ~m_lvl;
        exp_q.push_back({req, m_lvl});
        if (!b) m_lvl = ~m_lvl;
        exp_q.push_back({1'b0, m_lvl});
    endtask

    task automatic build_expected(input bit t, input bit gd);
        int n;
        logic [15:0] crc;
        n   = gd ? stim_bits.size() : MAXB;
        crc = 16'hFFFF;
        if (t) for (int i = 0; i < 24; i++) exp_q.push_back({1'b0, 1'((i % 2) == 0)});
        for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, PRE[11 - i]});
        m_lvl = 1'b1;
        for (int i = 0; i < n; i++) begin
            push_sym(stim_bits[i], 1'b1);
            crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ stim_bits[i]) ? 16'h1021 : 16'h0000);
        end
`ifdef TX_CRC16_EN
        for (int i = 15; i >= 0; i--) push_sym(~crc[i], 1'b0);
`else
        if (crc == 16'h0000) m_lvl = m_lvl;
`endif
        push_sym(1'b1, 1'b0);
        rec_q.push_back('{nreq: n, ovr: !gd});
    endtask

    task automatic fill_bits(input int n);
        stim_bits.delete();
        for (int i = 0; i < n; i++) stim_bits.push_back(1'($urandom));
    endtask

    task automatic send_reply(input bit t, input bit gd);
        @(negedge clk);
        build_expected(t, gd);
        data_q        = stim_bits;
        give_done     = gd;
        bif.trext     = t;
        bif.tx_start  = 1'b1;
        @(negedge clk);
        bif.tx_start  = 1'b0;
        bif.trext     = 1'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            seen = bif.tx_done;
        end
        check(name, 32'(seen), 1);
        @(negedge clk);
    endtask

    // Memory-side driver: present the next bit whenever the encoder requests one
    initial begin
        bif.tx_bit_src   = 1'b0;
        bif.tx_data_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bif.tx_bit_src   = 1'b0;
                bif.tx_data_done = 1'b0;
            end else if (bif.bit_req) begin
                if (data_q.size() > 0) begin
                    bif.tx_bit_src   = data_q.pop_front();
                    bif.tx_data_done = give_done && (data_q.size() == 0);
                end else begin
                    bif.tx_bit_src   = 1'($urandom);
                    bif.tx_data_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops one expected half-symbol per active cycle and closes each reply on tx_done
    initial begin
        bit         prev_active;
        int         nreq;
        logic [1:0] e;
        rec_t       r;
        prev_active = 1'b0;
        nreq        = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_active = 1'b0;
                nreq        = 0;
            end else begin
                if (bif.tx_active) begin
                    if (!prev_active) nreq = 0;
                    nreq += int'(bif.bit_req);
                    if (exp_q.size() == 0) begin
                        check("extra_halfsym", 32'({bif.bit_req, bif.tx_out}), 32'hEEEE);
                    end else begin
                        e = exp_q.pop_front();
                        check("halfsym", 32'({bif.bit_req, bif.tx_out}), 32'(e));
                    end
                    check("done_while_active", 32'(bif.tx_done), 0);
                end else begin
                    check("idle_out", 32'({bif.bit_req, bif.tx_out}), 0);
                    if (prev_active) begin
                        check("tx_done_pulse", 32'(bif.tx_done), 1);
                        check("halfsym_left", 32'(exp_q.size()), 0);
                        if (rec_q.size() == 0) begin
                            check("no_record", 1, 0);
                        end else begin
                            r = rec_q.pop_front();
                            check("bit_req_count", 32'(nreq), 32'(r.nreq));
                            check("tx_overrun", 32'(bif.tx_overrun), 32'(r.ovr));
                        end
                    end else begin
                        check("spurious_tx_done", 32'(bif.tx_done), 0);
                    end
                end
                prev_active = bif.tx_active;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bif.tx_start = 1'b0;
        bif.trext    = 1'b0;
        #1;
        check("rst_tx_out", 32'(bif.tx_out), 0);
        check("rst_tx_active", 32'(bif.tx_active), 0);
        check("rst_bit_req", 32'(bif.bit_req), 0);
        check("rst_tx_done", 32'(bif.tx_done), 0);
        check("rst_tx_overrun", 32'(bif.tx_overrun), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single data bit 1 terminated by tx_data_done
        stim_bits.delete();
        stim_bits.push_back(1'b1);
        send_reply(1'b0, 1'b1);
        wait_done("done_one_bit");

        // Bits 1,0
        stim_bits.delete();
        stim_bits.push_back(1'b1);
        stim_bits.push_back(1'b0);
        send_reply(1'b0, 1'b1);
        wait_done("done_two_bits");

        // Sixteen zero bits
        stim_bits.delete();
        for (int i = 0; i < 16; i++) stim_bits.push_back(1'b0);
        send_reply(1'b0, 1'b1);
        wait_done("done_zeros");

        // Pilot tone with a tx_start mid-reply that must be ignored
        fill_bits(6);
        send_reply(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        bif.trext    = 1'($urandom);
        bif.tx_start = 1'b1;
        @(negedge clk);
        bif.tx_start = 1'b0;
        wait_done("done_pilot");

        // Random replies
        for (int n = 0; n < 8; n++) begin
            fill_bits($urandom_range(1, 24));
            send_reply(1'($urandom), 1'b1);
            wait_done("done_random");
        end

        // Exactly MAX_BITS with tx_data_done on the last: no overrun
        fill_bits(MAXB);
        send_reply(1'b0, 1'b1);
        wait_done("done_maxbits_flagged");

        // tx_data_done never asserted: forced end and sticky overrun
        fill_bits(MAXB);
        send_reply(1'($urandom), 1'b0);
        wait_done("done_overrun");
        repeat (3) @(negedge clk);
        check("overrun_sticky", 32'(bif.tx_overrun), 1);

        // Next accepted start clears the overrun flag
        fill_bits(3);
        send_reply(1'b0, 1'b1);
        check("overrun_cleared", 32'(bif.tx_overrun), 0);
        wait_done("done_after_overrun");

        // Reset during data bit 5
        fill_bits(12);
        send_reply(1'b0, 1'b1);
        k = 0;
        for (int i = 0; i < BUDGET && k < 5; i++) begin
            @(negedge clk);
            if (bif.bit_req) k++;
        end
        check("reached_bit5", 32'(k), 5);
        check("active_before_reset", 32'(bif.tx_active), 1);
        #1 reset = 1'b1;
        #1;
        check("abort_tx_out", 32'(bif.tx_out), 0);
        check("abort_tx_active", 32'(bif.tx_active), 0);
        check("abort_bit_req", 32'(bif.bit_req), 0);
        check("abort_tx_done", 32'(bif.tx_done), 0);
        exp_q.delete();
        rec_q.delete();
        data_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Full reply after the abort
        fill_bits(9);
        send_reply(1'b1, 1'b1);
        wait_done("done_after_abort");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
